fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Shares one synchronous FIFO (DEPTH entries, push/full/usage/flush interface) among NUM_REQ producers.
- Arbitrates pushes round-robin and reserves RESERVE free entries for requester 0 (the high-priority producer).
- Runs a drain/flush control sequence so software can quiesce and clear the FIFO without corrupting in-flight transfers.
- Sits between the producers and the FIFO's push side; the pop side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, payload width
DEPTH, 8, depth of the attached FIFO (>=2)
ADDR_DEPTH, $clog2(DEPTH), width of the FIFO usage count (derived, do not override)
RESERVE, 1, free entries reserved for requester 0 (0..DEPTH-1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous reset, active low
req_valid_i  in  NUM_REQ  per-requester push valid
req_data_i  in  NUM_REQ*DATA_WIDTH  payloads, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
fifo_push_o  out  1  push to FIFO
fifo_data_o  out  DATA_WIDTH  data to FIFO
fifo_full_i  in  1  FIFO full
fifo_empty_i  in  1  FIFO empty
fifo_usage_i  in  ADDR_DEPTH  FIFO fill count, wraps to 0 when full
fifo_flush_o  out  1  FIFO flush strobe
drain_req_i  in  1  level: stop granting, wait for empty
flush_req_i  in  1  pulse: clear FIFO
ctrl_done_o  out  1  one-cycle pulse when a drain or flush completes
grant_idx_o  out  $clog2(NUM_REQ)  index of the last accepted requester
busy_o  out  1  FSM not in RUN

Behaviour:
- Reset values: rr_ptr=0, state=RUN, grant_idx_o=0, ctrl_done_o=0, fifo_flush_o=0, busy_o=0.
- Free-entry count: free = fifo_full_i ? 0 : DEPTH - fifo_usage_i. The zero-extended subtraction needs ADDR_DEPTH+1 bits.
- Eligibility:
  - Requester 0 is eligible when valid and free>0.
  - Requester i>0 is eligible when valid and free>RESERVE.
- Grant is combinational, zero-latency:
  - Winner is the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready_o[winner]=1 and fifo_push_o=1; fifo_data_o = winner's data.
  - Grants happen only in state RUN. With no winner, fifo_push_o=0 and fifo_data_o=0.
- Handshake: transfer occurs when req_valid_i[i] & req_ready_o[i]. Producers must hold valid and data stable until accepted.
- On transfer: rr_ptr <= (winner+1) mod NUM_REQ and grant_idx_o <= winner. Otherwise both hold.
- The block never asserts push while fifo_full_i=1.
- FSM:
  - RUN: flush_req_i -> FLUSH, which takes priority over drain. Otherwise drain_req_i -> DRAIN. No grants in the cycle the transition is taken.
  - DRAIN: no grants. When fifo_empty_i=1, pulse ctrl_done_o and go to HOLD. If flush_req_i arrives first -> FLUSH.
  - FLUSH: fifo_flush_o=1 for exactly one cycle, then -> HOLD with ctrl_done_o pulsed in the HOLD-entry cycle. rr_ptr resets to 0.
  - HOLD: no grants. Return to RUN when drain_req_i=0. A flush_req_i while in HOLD -> FLUSH.
  - busy_o=1 in DRAIN, FLUSH and HOLD.
- Simultaneous flush_req_i and a valid request in RUN: the flush wins and no push occurs that cycle.
- Reset mid-sequence returns to RUN immediately with all outputs at reset values.
- RESERVE=0 disables reservation, giving plain round-robin.

Test Plan:
- Round-robin fairness: NUM_REQ=4, all valid continuously, FIFO never full (pop every cycle) -> accept order 0,1,2,3,0,1..., grant_idx_o follows one cycle later, one push per cycle.
- Reservation: DEPTH=8, RESERVE=1, usage=7, requesters 1 and 2 valid -> no push. Then requester 0 valid -> pushed, FIFO full, all ready=0.
- Full boundary: fifo_full_i=1 with usage_i=0 (wrapped) -> free=0 and no grant for any requester, including requester 0.
- Drain: 3 entries queued, drain_req_i=1 while requesters are valid -> no pushes. After 3 pops and empty=1, ctrl_done_o pulses once and busy_o=1. drain_req_i=0 -> RUN, grants resume.
- Flush vs push: flush_req_i and req_valid_i[2] in the same cycle -> no push. fifo_flush_o high exactly 1 cycle, ctrl_done_o 1 cycle later, rr_ptr=0 so requester 0 wins first after RUN.
- Reset in DRAIN: assert rst_ni=0 mid-drain -> busy_o=0, ctrl_done_o=0, and grants available on the first cycle after release.

Source files
------------

// File: rtl/fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_push_arbiter
// Description : Round-robin push arbiter in front of a shared FIFO, with
//               reserved headroom for requester 0 and a drain/flush sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int ADDR_DEPTH = $clog2(DEPTH),
    parameter int RESERVE    = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            fifo_push_o,
    output logic [DATA_WIDTH-1:0]           fifo_data_o,
    input  logic                            fifo_full_i,
    input  logic                            fifo_empty_i,
    input  logic [ADDR_DEPTH-1:0]           fifo_usage_i,
    output logic                            fifo_flush_o,
    input  logic                            drain_req_i,
    input  logic                            flush_req_i,
    output logic                            ctrl_done_o,
    output logic [$clog2(NUM_REQ)-1:0]      grant_idx_o,
    output logic                            busy_o
);

    localparam int                  c_IDX_W   = $clog2(NUM_REQ);
    localparam int                  c_FREE_W  = ADDR_DEPTH + 1;
    localparam logic [c_FREE_W-1:0] c_DEPTH   = c_FREE_W'(DEPTH);
    localparam logic [c_FREE_W-1:0] c_RESERVE = c_FREE_W'(RESERVE);
    localparam logic [c_IDX_W-1:0]  c_LAST    = c_IDX_W'(NUM_REQ - 1);
    localparam logic [c_IDX_W:0]    c_NREQ    = (c_IDX_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_rr_ptr;
    logic [c_IDX_W-1:0]   r_grant_idx;
    logic                 r_ctrl_done;
    logic                 r_flush;
    logic                 r_busy;

    logic [c_FREE_W-1:0]  w_free;
    logic [NUM_REQ-1:0]   w_elig;
    logic                 w_grant_en;
    logic                 w_found;
    logic [c_IDX_W-1:0]   w_winner;
    logic [c_IDX_W:0]     w_sum;
    logic                 w_push;
    logic [c_IDX_W-1:0]   w_rr_next;

    // A full FIFO reports usage 0, so the full flag must override the count.
    assign w_free = fifo_full_i ? '0 : (c_DEPTH - {1'b0, fifo_usage_i});

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_elig
            if (gi == 0) begin : g_req0
                assign w_elig[gi] = req_valid_i[gi] && (w_free != '0);
            end else begin : g_reqn
                assign w_elig[gi] = req_valid_i[gi] && (w_free > c_RESERVE);
            end
        end
    endgenerate

    assign w_grant_en = (r_state == S_RUN) && !flush_req_i && !drain_req_i;

    // First eligible requester at or after the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (c_IDX_W + 1)'(k);
            if (w_sum >= c_NREQ) begin
                w_sum = w_sum - c_NREQ;
            end
            if (!w_found && w_elig[w_sum[c_IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[c_IDX_W-1:0];
            end
        end
    end

    assign w_push      = w_grant_en && w_found;
    assign w_rr_next   = (w_winner == c_LAST) ? '0 : (w_winner + 1'b1);

    assign fifo_push_o = w_push;
    assign req_ready_o = w_push ? (NUM_REQ'(1) << w_winner) : '0;
    assign fifo_data_o = w_push ? req_data_i[w_winner*DATA_WIDTH +: DATA_WIDTH] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_RUN;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_ctrl_done <= 1'b0;
            r_flush     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ctrl_done <= 1'b0;
            r_flush     <= 1'b0;
            if (w_push) begin
                r_rr_ptr    <= w_rr_next;
                r_grant_idx <= w_winner;
            end
            case (r_state)
                S_RUN: begin
                    if (flush_req_i) begin
                        r_state <= S_FLUSH;
                        r_flush <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (drain_req_i) begin
                        r_state <= S_DRAIN;
                        r_busy  <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (flush_req_i) begin
                        r_state <= S_FLUSH;
                        r_flush <= 1'b1;
                    end else if (fifo_empty_i) begin
                        r_state     <= S_HOLD;
                        r_ctrl_done <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    r_state     <= S_HOLD;
                    r_ctrl_done <= 1'b1;
                    r_rr_ptr    <= '0;
                end
                S_HOLD: begin
                    if (flush_req_i) begin
                        r_state <= S_FLUSH;
                        r_flush <= 1'b1;
                    end else if (!drain_req_i) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_flush_o = r_flush;
    assign ctrl_done_o  = r_ctrl_done;
    assign grant_idx_o  = r_grant_idx;
    assign busy_o       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_push_arbiter
// Description : Scoreboard bench for fifo_push_arbiter with a FIFO occupancy
//               model and counted producers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_push_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int DP = 8;
    localparam int AW = $clog2(DP);
    localparam int RS = 1;

    logic                   clk_i;
    logic                   rst_ni;
    logic [NR-1:0]          req_valid_i;
    logic [NR*DW-1:0]       req_data_i;
    logic [NR-1:0]          req_ready_o;
    logic                   fifo_push_o;
    logic [DW-1:0]          fifo_data_o;
    logic                   fifo_full_i;
    logic                   fifo_empty_i;
    logic [AW-1:0]          fifo_usage_i;
    logic                   fifo_flush_o;
    logic                   drain_req_i;
    logic                   flush_req_i;
    logic                   ctrl_done_o;
    logic [$clog2(NR)-1:0]  grant_idx_o;
    logic                   busy_o;

    fifo_push_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .RESERVE    (RS)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .fifo_push_o  (fifo_push_o),
        .fifo_data_o  (fifo_data_o),
        .fifo_full_i  (fifo_full_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_usage_i (fifo_usage_i),
        .fifo_flush_o (fifo_flush_o),
        .drain_req_i  (drain_req_i),
        .flush_req_i  (flush_req_i),
        .ctrl_done_o  (ctrl_done_o),
        .grant_idx_o  (grant_idx_o),
        .busy_o       (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_push = 0;
    int          cnt = 0;
    bit          pop_en = 1'b0;
    int          remaining [NR];
    int          sent [NR];
    logic [31:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int i, input int k);
        return {i[7:0], 8'h5A, k[15:0]};
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < NR; i++) begin
            req_valid_i[i]           = remaining[i] > 0;
            req_data_i[i*DW +: DW]   = mk(i, sent[i]);
        end
        fifo_full_i  = cnt >= DP;
        fifo_empty_i = cnt == 0;
        fifo_usage_i = AW'(cnt);
    endtask

    // One clock: score the push seen mid-cycle, then advance the FIFO and
    // producer models and re-drive the inputs just after the edge.
    task automatic tick();
        logic          s_push, s_flush, s_pop;
        logic [NR-1:0] s_ready;
        logic [31:0]   exp, one_hot;
        int            win;
        @(negedge clk_i);
        s_push  = fifo_push_o;
        s_ready = req_ready_o;
        s_flush = fifo_flush_o;
        s_pop   = pop_en && (cnt > 0);
        if (fifo_full_i) check_eq("push_when_full", 32'(fifo_push_o), 0);
        if (s_push) begin
            n_push++;
            if (exp_q.size() == 0) begin
                check_eq("push_expected", 32'(fifo_push_o), 0);
            end else begin
                exp     = exp_q.pop_front();
                one_hot = 32'd1 << exp[31:24];
                check_eq("push_data", fifo_data_o, exp);
                check_eq("push_ready", 32'(req_ready_o), one_hot);
            end
        end
        @(posedge clk_i);
        #1;
        if (s_flush) cnt = 0;
        else         cnt = cnt + int'(s_push) - int'(s_pop);
        win = 0;
        for (int i = 0; i < NR; i++) begin
            if (s_ready[i] && req_valid_i[i]) begin
                sent[i]++;
                remaining[i]--;
                win = i;
            end
        end
        if (s_push) check_eq("grant_idx", 32'(grant_idx_o), win);
        drive_inputs();
        #1;
    endtask

    initial begin
        int p0;
        rst_ni      = 1'b0;
        drain_req_i = 1'b0;
        flush_req_i = 1'b0;
        req_valid_i = '0;
        req_data_i  = '0;
        for (int i = 0; i < NR; i++) begin
            remaining[i] = 0;
            sent[i]      = 0;
        end
        drive_inputs();
        repeat (3) tick();
        check_eq("rst_busy", 32'(busy_o), 0);
        check_eq("rst_done", 32'(ctrl_done_o), 0);
        check_eq("rst_flush", 32'(fifo_flush_o), 0);
        check_eq("rst_gidx", 32'(grant_idx_o), 0);
        check_eq("rst_push", 32'(fifo_push_o), 0);
        rst_ni = 1'b1;

        // Round-robin fairness with the FIFO popped every cycle.
        pop_en = 1'b1;
        for (int i = 0; i < NR; i++) remaining[i] = 2;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < NR; i++) exp_q.push_back(mk(i, k));
        drive_inputs();
        p0 = n_push;
        repeat (8) tick();
        check_eq("rr_push_count", n_push - p0, 8);
        repeat (2) tick();
        check_eq("rr_sb_empty", exp_q.size(), 0);

        // Reservation: one free entry is kept for requester 0.
        pop_en = 1'b0;
        cnt = DP - 1;
        remaining[1] = 1;
        remaining[2] = 1;
        drive_inputs();
        #1;
        check_eq("rsv_ready_lo", 32'(req_ready_o), 0);
        check_eq("rsv_push_lo", 32'(fifo_push_o), 0);
        tick();
        check_eq("rsv_ready_lo2", 32'(req_ready_o), 0);
        remaining[0] = 1;
        exp_q.push_back(mk(0, sent[0]));
        drive_inputs();
        #1;
        check_eq("rsv_ready_r0", 32'(req_ready_o), 32'h1);
        tick();
        check_eq("full_ready", 32'(req_ready_o), 0);
        check_eq("full_push", 32'(fifo_push_o), 0);
        remaining[0] = 1;
        drive_inputs();
        #1;
        check_eq("full_ready_r0", 32'(req_ready_o), 0);
        tick();
        check_eq("full_sb_empty", exp_q.size(), 0);

        // Drain with three entries queued.
        cnt = 3;
        for (int i = 0; i < NR; i++) remaining[i] = 1;
        drain_req_i = 1'b1;
        drive_inputs();
        #1;
        check_eq("drn_ready_lo", 32'(req_ready_o), 0);
        tick();
        check_eq("drn_busy", 32'(busy_o), 1);
        tick();
        pop_en = 1'b1;
        repeat (3) tick();
        check_eq("drn_done_early", 32'(ctrl_done_o), 0);
        tick();
        check_eq("drn_done", 32'(ctrl_done_o), 1);
        check_eq("drn_busy_hold", 32'(busy_o), 1);
        tick();
        check_eq("drn_done_once", 32'(ctrl_done_o), 0);
        drain_req_i = 1'b0;
        #1;
        check_eq("hold_ready_lo", 32'(req_ready_o), 0);
        exp_q.push_back(mk(1, sent[1]));
        exp_q.push_back(mk(2, sent[2]));
        exp_q.push_back(mk(3, sent[3]));
        exp_q.push_back(mk(0, sent[0]));
        tick();
        check_eq("drn_run_busy", 32'(busy_o), 0);
        p0 = n_push;
        repeat (4) tick();
        check_eq("drn_resume_pushes", n_push - p0, 4);
        check_eq("drn_sb_empty", exp_q.size(), 0);

        // Flush beats a simultaneous request and rewinds the pointer.
        pop_en = 1'b0;
        remaining[0] = 1;
        remaining[2] = 1;
        flush_req_i = 1'b1;
        drive_inputs();
        #1;
        check_eq("fl_push_lo", 32'(fifo_push_o), 0);
        exp_q.push_back(mk(0, sent[0]));
        exp_q.push_back(mk(2, sent[2]));
        tick();
        flush_req_i = 1'b0;
        #1;
        check_eq("fl_flush_hi", 32'(fifo_flush_o), 1);
        check_eq("fl_busy", 32'(busy_o), 1);
        check_eq("fl_done_lo", 32'(ctrl_done_o), 0);
        check_eq("fl_ready_lo", 32'(req_ready_o), 0);
        tick();
        check_eq("fl_flush_once", 32'(fifo_flush_o), 0);
        check_eq("fl_done", 32'(ctrl_done_o), 1);
        tick();
        check_eq("fl_done_once", 32'(ctrl_done_o), 0);
        check_eq("fl_run_busy", 32'(busy_o), 0);
        check_eq("fl_r0_first", 32'(req_ready_o), 32'h1);
        repeat (2) tick();
        check_eq("fl_sb_empty", exp_q.size(), 0);

        // Reset while draining.
        cnt = 3;
        drain_req_i = 1'b1;
        drive_inputs();
        tick();
        check_eq("rd_busy", 32'(busy_o), 1);
        tick();
        rst_ni = 1'b0;
        drain_req_i = 1'b0;
        #1;
        check_eq("rd_busy_lo", 32'(busy_o), 0);
        check_eq("rd_done_lo", 32'(ctrl_done_o), 0);
        check_eq("rd_gidx", 32'(grant_idx_o), 0);
        check_eq("rd_flush_lo", 32'(fifo_flush_o), 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        remaining[1] = 1;
        exp_q.push_back(mk(1, sent[1]));
        drive_inputs();
        #1;
        check_eq("rd_grant_now", 32'(req_ready_o), 32'h2);
        tick();
        tick();
        check_eq("rd_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
